// File: rtl/ariane_pkg.sv
// Slice of the shared core package: the branch-history update type and the
// default depth of the update queue that sits in front of the BHT.
package ariane_pkg;

  localparam int unsigned VLEN = 64;

  localparam int unsigned BHT_UPD_FIFO_DEPTH = 4;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

endpackage

// File: rtl/bht_upd_fifo.sv
// Circular FIFO with two write lanes and one read lane. The caller decides how
// many entries to push (0..2); lane 0 always lands at the write pointer.
module bht_upd_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = BHT_UPD_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [1:0]               push_num_i,
  input  bht_update_t [1:0]        wdata_i,
  input  logic                     pop_i,
  output bht_update_t              head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]            rptr_q, rptr_d;
  logic [PW-1:0]            wptr_q, wptr_d;
  logic [PW-1:0]            wptr_nxt;
  logic [CW-1:0]            count_q, count_d;
  bht_update_t [DEPTH-1:0]  mem_q, mem_d;

  // DEPTH is a power of two, so pointer arithmetic wraps on its own.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    mem_d    = mem_q;
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    count_d  = count_q;
    wptr_nxt = wptr_q + PW'(1);
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_num_i != 2'd0) mem_d[wptr_q]   = wdata_i[0];
      if (push_num_i == 2'd2) mem_d[wptr_nxt] = wdata_i[1];
      wptr_d  = wptr_q + PW'(push_num_i);
      rptr_d  = rptr_q + PW'(pop_i);
      count_d = count_q + CW'(push_num_i) - CW'(pop_i);
    end
  end

  // NOTE: sequential state is assigned with non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload storage has no reset; an entry is only ever read while count_q says it holds valid data.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bht_update_arbiter.sv
// Serializes up to two commit-time BHT updates per cycle into a single update
// per cycle, dropping (and counting) whatever does not fit in the queue.
module bht_update_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = BHT_UPD_FIFO_DEPTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_bp_i,
  input  bht_update_t [1:0]        upd_i,
  input  logic                     bht_ready_i,
  output bht_update_t              bht_update_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned FW = CW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CW-1:0]      count;
  bht_update_t        head;
  logic               head_valid;
  logic               deq;
  logic [FW-1:0]      free;
  logic [1:0]         n_valid, n_push, n_drop;
  bht_update_t [1:0]  wdata;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  always_comb begin
    head_valid = (count != '0);
    deq        = head_valid & bht_ready_i & ~flush_bp_i;
    // A slot freed by this cycle's dequeue is reusable in the same cycle.
    free       = FW'(DEPTH) - FW'(count) + FW'(deq);
    n_valid    = {1'b0, upd_i[0].valid} + {1'b0, upd_i[1].valid};
    n_push     = (free >= FW'(n_valid)) ? n_valid : free[1:0];
    // Compaction: a lone port-1 update takes lane 0.
    wdata[0]   = upd_i[0].valid ? upd_i[0] : upd_i[1];
    wdata[1]   = upd_i[1];
    if (flush_bp_i) n_push = 2'd0;
    n_drop     = flush_bp_i ? 2'd0 : (n_valid - n_push);

    if (CNT_W'(n_drop) > CNT_MAX - drop_cnt_q) drop_cnt_d = CNT_MAX;
    else                                       drop_cnt_d = drop_cnt_q + CNT_W'(n_drop);

    bht_update_o = '0;
    if (head_valid) begin
      bht_update_o       = head;
      bht_update_o.valid = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  bht_upd_fifo #(
    .DEPTH (DEPTH)
  ) i_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_bp_i),
    .push_num_i (n_push),
    .wdata_i    (wdata),
    .pop_i      (deq),
    .head_o     (head),
    .count_o    (count)
  );

  assign count_o    = count;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bht_update_arbiter.sv
// Bench for bht_update_arbiter: a queue-based reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_bht_update_arbiter;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DROP_MAX = 65535;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_bp_i = 1'b0;
  bht_update_t [1:0] upd_i = '0;
  logic              bht_ready_i = 1'b0;
  bht_update_t       bht_update_o;
  logic [2:0]        count_o;
  logic [CNT_W-1:0]  drop_cnt_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          run_cmp  = 1'b0;

  bht_update_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_bp_i   (flush_bp_i),
    .upd_i        (upd_i),
    .bht_ready_i  (bht_ready_i),
    .bht_update_o (bht_update_o),
    .count_o      (count_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bht_update_t upd(input logic [VLEN-1:0] pc, input logic taken);
    upd = '0;
    upd.valid = 1'b1;
    upd.pc    = pc;
    upd.taken = taken;
  endfunction

  // Reference model: a plain queue with the free-slot / drop rules.
  bht_update_t mq[$];
  int unsigned m_drop = 0;
  int          m_free;
  int          m_drops;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      m_drop = 0;
    end else if (flush_bp_i) begin
      mq.delete();
    end else begin
      m_drops = 0;
      m_free  = DEPTH - mq.size();
      if (mq.size() > 0 && bht_ready_i) begin
        void'(mq.pop_front());
        m_free++;
      end
      for (int p = 0; p < 2; p++) begin
        if (upd_i[p].valid) begin
          if (m_free > 0) begin
            mq.push_back(upd_i[p]);
            m_free--;
          end else begin
            m_drops++;
          end
        end
      end
      m_drop = (m_drop + m_drops > DROP_MAX) ? DROP_MAX : m_drop + m_drops;
    end
  end

  bht_update_t exp_out;
  always @(negedge clk_i) begin
    if (run_cmp) begin
      exp_out = '0;
      if (mq.size() > 0) exp_out = mq[0];
      check("cycle", {bht_update_o, count_o, drop_cnt_o},
            {exp_out, 3'(mq.size()), CNT_W'(m_drop)});
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bht_update_t u0, input bht_update_t u1, input logic rdy);
    upd_i[0]    = u0;
    upd_i[1]    = u1;
    bht_ready_i = rdy;
  endtask

  task automatic drive_random();
    upd_i[0]    = $urandom_range(0, 1) ? upd($urandom(), 1'($urandom())) : '0;
    upd_i[1]    = $urandom_range(0, 1) ? upd($urandom(), 1'($urandom())) : '0;
    bht_ready_i = 1'($urandom());
    flush_bp_i  = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    run_cmp = 1'b1;
    repeat (3) cycle();
    check("reset_state", {bht_update_o, count_o, drop_cnt_o}, '0);
    rst_ni = 1'b1;
    cycle();

    // Single update into empty FIFO, visible next cycle, gone the cycle after.
    drive(upd(64'h100, 1'b1), '0, 1'b1);
    cycle();
    drive('0, '0, 1'b1);
    check("single_out", bht_update_o, upd(64'h100, 1'b1));
    check("single_cnt", count_o, 3'd1);
    cycle();
    check("single_drained", {bht_update_o.valid, count_o}, {1'b0, 3'd0});

    // Dual enqueue while BHT is stalled, then ordered drain.
    drive(upd(64'h200, 1'b0), upd(64'h204, 1'b1), 1'b0);
    cycle();
    drive('0, '0, 1'b0);
    check("dual_cnt", count_o, 3'd2);
    check("dual_head0", bht_update_o, upd(64'h200, 1'b0));
    bht_ready_i = 1'b1;
    cycle();
    check("dual_head1", bht_update_o, upd(64'h204, 1'b1));
    cycle();
    check("dual_empty", count_o, 3'd0);

    // Partial fit: fill to 3, then one of two fits, then one fits with dequeue.
    drive(upd(64'h300, 1'b0), upd(64'h304, 1'b0), 1'b0);
    cycle();
    drive(upd(64'h308, 1'b1), '0, 1'b0);
    cycle();
    check("fill3_cnt", count_o, 3'd3);
    drive(upd(64'h30c, 1'b0), upd(64'h310, 1'b1), 1'b0);
    cycle();
    check("partial_cnt", count_o, 3'd4);
    check("partial_drop", drop_cnt_o, 16'd1);
    drive(upd(64'h314, 1'b1), upd(64'h318, 1'b0), 1'b1);
    cycle();
    check("deq_fit_cnt", count_o, 3'd4);
    check("deq_fit_drop", drop_cnt_o, 16'd2);
    check("deq_fit_head", bht_update_o, upd(64'h304, 1'b0));

    // Full, both valid, stalled: two drops, contents intact.
    drive(upd(64'h31c, 1'b0), upd(64'h320, 1'b0), 1'b0);
    cycle();
    check("full_drop", drop_cnt_o, 16'd4);
    check("full_cnt", count_o, 3'd4);
    drive('0, '0, 1'b1);
    cycle();
    check("drain_c", bht_update_o, upd(64'h308, 1'b1));
    cycle();
    check("drain_d", bht_update_o, upd(64'h30c, 1'b0));
    cycle();
    check("drain_e", bht_update_o, upd(64'h314, 1'b1));
    cycle();
    check("drain_empty", count_o, 3'd0);

    // Lone port-1 update is compacted, then flush with same-cycle input.
    drive('0, upd(64'h400, 1'b0), 1'b0);
    cycle();
    check("compact_cnt", count_o, 3'd1);
    check("compact_head", bht_update_o, upd(64'h400, 1'b0));
    drive(upd(64'h404, 1'b1), upd(64'h408, 1'b1), 1'b0);
    cycle();
    check("pre_flush_cnt", count_o, 3'd3);
    drive(upd(64'h40c, 1'b1), '0, 1'b1);
    flush_bp_i = 1'b1;
    cycle();
    flush_bp_i = 1'b0;
    drive('0, '0, 1'b0);
    check("flush_state", {bht_update_o, count_o, drop_cnt_o}, {66'd0, 3'd0, 16'd4});

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive_random();
      cycle();
    end
    flush_bp_i = 1'b0;

    // Saturate the drop counter with a full, stalled queue.
    drive(upd(64'h500, 1'b0), upd(64'h504, 1'b1), 1'b0);
    for (int i = 0; i < 33000; i++) cycle();
    check("sat_value", drop_cnt_o, 16'hffff);
    check("sat_cnt", count_o, 3'd4);
    repeat (4) cycle();
    check("sat_hold", drop_cnt_o, 16'hffff);

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 20; i++) begin
      drive_random();
      cycle();
    end
    #1 rst_ni = 1'b0;
    #1;
    check("async_rst", {bht_update_o, count_o, drop_cnt_o}, '0);
    cycle();
    drive('0, '0, 1'b1);
    flush_bp_i = 1'b0;
    cycle();
    rst_ni = 1'b1;
    cycle();
    check("post_rst_idle", {bht_update_o.valid, count_o}, {1'b0, 3'd0});

    for (int i = 0; i < 300; i++) begin
      drive_random();
      cycle();
    end

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bht_update_arbiter.md
BHT_UPDATE_ARBITER -- requirements
Module: bht_update_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning pending-update queue entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning drop-counter width.
REQ-003 SHALL have port clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_bp_i  input  1  discard all pending updates.
REQ-006 SHALL have port upd_i  input  2 x bht_update_t  commit-port updates {valid, pc[VLEN-1:0], taken}; index 0 is older in program order.
REQ-007 SHALL have port bht_ready_i  input  1  BHT accepts an update this cycle.
REQ-008 SHALL have port bht_update_o  output  bht_update_t  single serialized update to the BHT.
REQ-009 SHALL have port count_o  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-010 SHALL have port drop_cnt_o  output  CNT_W  saturating count of discarded updates.

Function
REQ-011 SHALL hold updates in a circular FIFO with read pointer, write pointer and occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-012 SHALL drive bht_update_o from the FIFO head, with bht_update_o.valid = (count != 0); no combinational path from upd_i to bht_update_o.
REQ-013 SHALL dequeue the head when bht_update_o.valid and bht_ready_i are both high.
REQ-014 SHALL compute free slots as DEPTH - count + (dequeue this cycle ? 1 : 0).
REQ-015 SHALL enqueue valid upd_i entries in index order 0 then 1, writing both in one cycle when free slots >= 2.
REQ-016 SHALL, when only one valid update fits, enqueue the lower-indexed valid port and drop the other.
REQ-017 SHALL, when no update fits, drop all valid inputs.
REQ-018 SHALL compact inputs: if only upd_i[1] is valid, it occupies one slot at the write pointer.
REQ-019 SHALL increment drop_cnt_o by the number of dropped updates (0, 1 or 2), saturating at 2^CNT_W-1.
REQ-020 SHALL give an update accepted in cycle N into an empty FIFO at bht_update_o in cycle N+1.
REQ-021 SHALL, on flush_bp_i high, empty the FIFO at the next edge: pointers and count cleared, and same-cycle inputs and dequeue ignored.
REQ-022 SHALL not count inputs discarded by flush as drops; drop_cnt_o is unchanged by flush.
REQ-023 SHALL hold queue contents, pointers and count stable when bht_ready_i is low, apart from enqueues.
REQ-024 SHALL make count_o never exceed DEPTH, including simultaneous dequeue and double enqueue when full.

Reset
REQ-025 SHALL, on rst_ni low, asynchronously clear pointers, count_o = 0, drop_cnt_o = 0, and bht_update_o.valid = 0.
REQ-026 SHALL not require FIFO payload storage to be reset; its contents are don't-care while invalid.
REQ-027 SHALL treat reset mid-operation as discarding all pending updates, with no update emitted after deassertion until a new enqueue.

Structure
REQ-028 SHALL take bht_update_t and VLEN from the shared packages (ariane_pkg / config_pkg), with no local redefinition.
REQ-029 SHALL place DEPTH default BHT_UPD_FIFO_DEPTH in the shared package.
REQ-030 SHALL be naturally split into one sub-module, bht_upd_fifo (2-write/1-read FIFO storage plus pointers), with the arbitration, drop and flush logic in the top level.

Verification
REQ-031 Verification SHALL cover: empty FIFO, upd_i[0]={1,0x100,1} with bht_ready_i=1 -> bht_update_o={1,0x100,1} next cycle, count_o returns to 0 the cycle after.
REQ-032 Verification SHALL cover: both ports valid (pc 0x200, 0x204) with bht_ready_i=0 -> count_o=2 and output order 0x200 then 0x204 once ready.
REQ-033 Verification SHALL cover: count_o=3 (DEPTH 4), both ports valid, no dequeue -> port 0 enqueued, count_o=4, drop_cnt_o +1; then both valid with dequeue -> one enqueued, count_o=4, drop_cnt_o +1.
REQ-034 Verification SHALL cover: full FIFO, both valid, bht_ready_i=0 -> drop_cnt_o +2, contents unchanged.
REQ-035 Verification SHALL cover: count_o=3 with flush_bp_i and upd_i[0] valid in the same cycle -> count_o=0, valid=0 next cycle, drop_cnt_o unchanged.
REQ-036 Verification SHALL cover: drop_cnt_o preset to 0xFFFF by repeated drops -> it stays 0xFFFF; rst_ni pulse mid-traffic -> all outputs 0 immediately.
